// File: rtl/hyperram_bus_bridge.sv
// picorv32 native bus to hyper_xface bridge: one dword per transaction, posted writes, blocking reads.
// Optional watchdog enabled by defining HYPERRAM_BRIDGE_TIMEOUT_EN.
module hyperram_bus_bridge #(
   parameter logic [3:0] WINDOW         = 4'h2,
   parameter logic [7:0] LAT_1X         = 8'd6,
   parameter logic [7:0] LAT_2X         = 8'd12,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [31:0] s_addr,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   output logic        s_ready,
   output logic [31:0] s_rdata,
   output logic        ctl_rd_req,
   output logic        ctl_wr_req,
   output logic        ctl_mem_or_reg,
   output logic [3:0]  ctl_wr_byte_en,
   output logic [5:0]  ctl_rd_num_dwords,
   output logic [31:0] ctl_addr,
   output logic [31:0] ctl_wr_d,
   input  logic [31:0] ctl_rd_d,
   input  logic        ctl_rd_rdy,
   input  logic        ctl_busy,
   output logic [7:0]  ctl_latency_1x,
   output logic [7:0]  ctl_latency_2x,
   output logic        o_timeout
);

   // state    | meaning
   // IDLE     | waiting for a selected CPU access with the controller free
   // WAIT_ACC | write issued, waiting for the controller to go busy
   // WAIT_RD  | read issued, waiting for ctl_rd_rdy
   // ACK      | s_ready high for this one cycle
   typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_RD, ACK} state_t;

   // The watchdog counter is 16 bits wide, so the limit must fit.
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
      $error("hyperram_bus_bridge: TIMEOUT_CYCLES out of range");
   end

   state_t      state_q, state_d;
   logic        s_ready_q, s_ready_d;
   logic [31:0] s_rdata_q, s_rdata_d;
   logic        rd_req_q, rd_req_d;
   logic        wr_req_q, wr_req_d;
   logic        mem_or_reg_q, mem_or_reg_d;
   logic [3:0]  byte_en_q, byte_en_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wr_d_q, wr_d_d;
   logic        sel;

`ifdef HYPERRAM_BRIDGE_TIMEOUT_EN
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
`endif

   assign sel = s_valid && (s_addr[31:28] == WINDOW);

   always_comb begin
      state_d      = state_q;
      s_ready_d    = 1'b0;
      s_rdata_d    = s_rdata_q;
      rd_req_d     = 1'b0;
      wr_req_d     = 1'b0;
      mem_or_reg_d = mem_or_reg_q;
      byte_en_d    = byte_en_q;
      addr_d       = addr_q;
      wr_d_d       = wr_d_q;
`ifdef HYPERRAM_BRIDGE_TIMEOUT_EN
      cnt_d        = '0;
      timeout_d    = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            // Busy here usually means a posted write is still draining.
            if (sel && !ctl_busy) begin
               mem_or_reg_d = s_addr[27];
               addr_d       = {5'b0, s_addr[26:0]};
               byte_en_d    = s_wstrb;
               wr_d_d       = s_wdata;
               if (s_wstrb != 4'b0000) begin
                  wr_req_d = 1'b1;
                  state_d  = WAIT_ACC;
               end else begin
                  rd_req_d = 1'b1;
                  state_d  = WAIT_RD;
               end
            end
         end
         WAIT_ACC: begin
            if (ctl_busy) begin
               s_ready_d = 1'b1;
               state_d   = ACK;
            end
`ifdef HYPERRAM_BRIDGE_TIMEOUT_EN
            else if (cnt_q == TO_LIMIT) begin
               s_ready_d = 1'b1;
               timeout_d = 1'b1;
               state_d   = ACK;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         WAIT_RD: begin
            if (ctl_rd_rdy) begin
               s_rdata_d = ctl_rd_d;
               s_ready_d = 1'b1;
               state_d   = ACK;
            end
`ifdef HYPERRAM_BRIDGE_TIMEOUT_EN
            else if (cnt_q == TO_LIMIT) begin
               s_rdata_d = 32'hDEAD_BEEF;
               s_ready_d = 1'b1;
               timeout_d = 1'b1;
               state_d   = ACK;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         s_ready_q    <= 1'b0;
         s_rdata_q    <= '0;
         rd_req_q     <= 1'b0;
         wr_req_q     <= 1'b0;
         mem_or_reg_q <= 1'b0;
         byte_en_q    <= '0;
         addr_q       <= '0;
         wr_d_q       <= '0;
      end else begin
         state_q      <= state_d;
         s_ready_q    <= s_ready_d;
         s_rdata_q    <= s_rdata_d;
         rd_req_q     <= rd_req_d;
         wr_req_q     <= wr_req_d;
         mem_or_reg_q <= mem_or_reg_d;
         byte_en_q    <= byte_en_d;
         addr_q       <= addr_d;
         wr_d_q       <= wr_d_d;
      end
   end

`ifdef HYPERRAM_BRIDGE_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   assign s_ready           = s_ready_q;
   assign s_rdata           = s_rdata_q;
   assign ctl_rd_req        = rd_req_q;
   assign ctl_wr_req        = wr_req_q;
   assign ctl_mem_or_reg    = mem_or_reg_q;
   assign ctl_wr_byte_en    = byte_en_q;
   assign ctl_addr          = addr_q;
   assign ctl_wr_d          = wr_d_q;
   assign ctl_rd_num_dwords = 6'd1;
   assign ctl_latency_1x    = LAT_1X;
   assign ctl_latency_2x    = LAT_2X;

endmodule
